// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes rxd, oversamples each bit at mid-bit and
// holds the received byte in a one-deep buffer with sticky
// ready/overrun/frame-error status until the CPU acknowledges the read.
module uart_rx_core #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVS      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_ferr,
    output logic       rx_busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVS);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMP_W = $clog2(OVS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVS / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVS - 1);

    // Reject parameter sets that cannot place a sample at mid-bit.
    if (OVS < 8 || (OVS % 2) != 0) begin : g_bad_ovs
        $error("uart_rx_core: OVS must be even and at least 8");
    end
    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_core: CLK_FREQ too low for BAUD*OVS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    logic             sync1_q, rxs_q, rxs_prev_q;
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             good_byte;
    logic             bad_stop;

    // Two-flop synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Next-state logic: tick/sample/bit counters, frame FSM and status flags.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        smp_d     = smp_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ready_d   = ready_q;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
        good_byte = 1'b0;
        bad_stop  = 1'b0;

        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
            smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Restart the tick phase so samples line up with the start edge.
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    div_d   = '0;
                    smp_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (tick && smp_q == SMP_MID) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        smp_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick && smp_q == SMP_LAST) begin
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && smp_q == SMP_LAST) begin
                    if (rxs_q) begin
                        good_byte = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        bad_stop = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must go high before another start is accepted.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_ack) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
            ferr_d  = 1'b0;
        end
        // A new byte wins over a coincident ack; overrun only if unread and not acked.
        if (good_byte) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            ready_d = 1'b1;
            ovr_d   = ready_q & ~rx_ack;
        end
        if (bad_stop) begin
            ferr_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            smp_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_ready   = ready_q;
    assign rx_overrun = ovr_q;
    assign rx_ferr    = ferr_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed table of frames, hand-written corner
// sequences and randomized frames checked against a byte-level model.
module tb_uart_rx_core;

    // Scaled clock/baud so a frame is a few hundred cycles: 4 clk per tick.
    localparam int unsigned CLK_FREQ = 6144000;
    localparam int unsigned BAUD     = 96000;
    localparam int unsigned OVS      = 16;
    localparam int unsigned DIV      = CLK_FREQ / (BAUD * OVS);
    localparam int unsigned BIT      = OVS * DIV;
    // Start edge to rx_valid: 2 sync clk + 1 edge compare + half bit + 9 bits.
    localparam int unsigned LAT      = 3 + (OVS / 2) * DIV + 9 * BIT;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       rx_ferr;
    logic       rx_busy;

    uart_rx_core #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .OVS     (OVS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_overrun(rx_overrun),
        .rx_ferr   (rx_ferr),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;

    // Reference model state: what the CPU should see after each frame.
    logic [7:0] m_data;
    bit         m_ready, m_ovr, m_ferr;
    int         m_valid;

    typedef struct {
        logic [7:0] d;
        bit         stop;
        int         gap;
        bit         ack;
        logic [7:0] e_data;
        bit         e_ready;
        bit         e_ovr;
        bit         e_ferr;
    } vec_t;

    vec_t tbl[4];

    // Every clk that rx_valid is high counts as one delivered byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) valid_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        wait_clks(n);
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; rxd is left at 'stop'.
    task automatic drive_frame(input logic [7:0] d, input bit stop, input int bc);
        rxd = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clks(bc);
        end
        rxd = stop;
        wait_clks(bc);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        wait_clks(1);
        rx_ack = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop, input bit ack_same);
        if (stop) begin
            m_ovr   = m_ready && !ack_same;
            if (ack_same) m_ferr = 1'b0;
            m_data  = d;
            m_ready = 1'b1;
            m_valid++;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic model_ack();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk($sformatf("%s.data", tag), 32'(rx_data), 32'(m_data));
        chk($sformatf("%s.ready", tag), 32'(rx_ready), 32'(m_ready));
        chk($sformatf("%s.overrun", tag), 32'(rx_overrun), 32'(m_ovr));
        chk($sformatf("%s.ferr", tag), 32'(rx_ferr), 32'(m_ferr));
        chk($sformatf("%s.busy", tag), 32'(rx_busy), 32'(0));
        chk($sformatf("%s.valid_count", tag), 32'(valid_cycles), 32'(m_valid));
    endtask

    initial begin
        int busy_seen;
        logic [7:0] d;
        bit stop;
        int bc;

        tbl[0] = '{8'hFA, 1'b1, 1, 1'b0, 8'hFA, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h32, 1'b1, 1, 1'b1, 8'h32, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'hA5, 1'b0, 1, 1'b0, 8'h32, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b1, 1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};

        reset  = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        m_valid = 0;
        model_reset();
        wait_clks(5);
        check_model("reset");
        reset = 1'b1;

        // Idle line for ten bit times: nothing may happen.
        busy_seen = 0;
        for (int i = 0; i < int'(10 * BIT); i++) begin
            @(negedge clk);
            if (rx_busy !== 1'b0) busy_seen++;
        end
        chk("idle.busy_cycles", 32'(busy_seen), 32'(0));
        check_model("idle");

        // Directed frames with constant expectations.
        for (int r = 0; r < 4; r++) begin
            drive_frame(tbl[r].d, tbl[r].stop, int'(BIT));
            if (!tbl[r].stop) begin
                wait_clks(int'(2 * BIT));
                chk($sformatf("tbl%0d.busy_in_break", r), 32'(rx_busy), 32'(1));
                chk($sformatf("tbl%0d.ferr_in_break", r), 32'(rx_ferr), 32'(1));
            end
            idle(tbl[r].gap * int'(BIT));
            model_frame(tbl[r].d, tbl[r].stop, 1'b0);
            chk($sformatf("tbl%0d.data", r), 32'(rx_data), 32'(tbl[r].e_data));
            chk($sformatf("tbl%0d.ready", r), 32'(rx_ready), 32'(tbl[r].e_ready));
            chk($sformatf("tbl%0d.overrun", r), 32'(rx_overrun), 32'(tbl[r].e_ovr));
            chk($sformatf("tbl%0d.ferr", r), 32'(rx_ferr), 32'(tbl[r].e_ferr));
            chk($sformatf("tbl%0d.busy", r), 32'(rx_busy), 32'(0));
            chk($sformatf("tbl%0d.valid_count", r), 32'(valid_cycles), 32'(m_valid));
            if (tbl[r].ack) begin
                pulse_ack();
                model_ack();
                chk($sformatf("tbl%0d.ack_ready", r), 32'(rx_ready), 32'(0));
                chk($sformatf("tbl%0d.ack_overrun", r), 32'(rx_overrun), 32'(0));
                chk($sformatf("tbl%0d.ack_ferr", r), 32'(rx_ferr), 32'(0));
                chk($sformatf("tbl%0d.ack_data", r), 32'(rx_data), 32'(tbl[r].e_data));
            end
        end

        // Short low glitch is rejected at the mid-start sample.
        rxd = 1'b0;
        wait_clks(4);
        idle(int'(2 * BIT));
        check_model("glitch");
        drive_frame(8'h55, 1'b1, int'(BIT));
        idle(int'(BIT));
        model_frame(8'h55, 1'b1, 1'b0);
        check_model("after_glitch");

        // Ack landing on the same clk as rx_valid while a byte is still pending.
        fork
            drive_frame(8'h96, 1'b1, int'(BIT));
            begin
                wait_clks(int'(LAT) - 1);
                rx_ack = 1'b1;
                wait_clks(1);
                chk("coinc.valid", 32'(rx_valid), 32'(1));
                rx_ack = 1'b0;
            end
        join
        idle(int'(BIT));
        model_frame(8'h96, 1'b1, 1'b1);
        check_model("coinc");

        // Reset asserted in the middle of data bit 4.
        d = 8'h6B;
        rxd = 1'b0;
        wait_clks(int'(BIT));
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            wait_clks(int'(BIT));
        end
        rxd = d[4];
        wait_clks(int'(BIT / 2));
        reset = 1'b0;
        #1;
        chk("midreset.data", 32'(rx_data), 32'(0));
        chk("midreset.ready", 32'(rx_ready), 32'(0));
        chk("midreset.busy", 32'(rx_busy), 32'(0));
        chk("midreset.valid", 32'(rx_valid), 32'(0));
        @(negedge clk);
        rxd = 1'b1;
        wait_clks(4);
        reset = 1'b1;
        model_reset();
        idle(int'(2 * BIT));
        drive_frame(8'hC3, 1'b1, int'(BIT));
        idle(int'(BIT));
        model_frame(8'hC3, 1'b1, 1'b0);
        check_model("after_reset");

        // Randomized frames with up to +/-3% bit-rate error.
        for (int r = 0; r < 20; r++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            bc   = int'($urandom_range(62, 66));
            drive_frame(d, stop, bc);
            if (!stop) wait_clks(bc * int'($urandom_range(1, 2)));
            idle(bc / 2 + int'($urandom_range(0, 64)));
            model_frame(d, stop, 1'b0);
            check_model($sformatf("rand%0d", r));
            if ($urandom_range(0, 2) == 0) begin
                pulse_ack();
                model_ack();
                check_model($sformatf("rand%0d_ack", r));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive front end feeding the CPU's UART peripheral registers. Converts the asynchronous 8N1 UART_rxd line into parallel bytes.
- Holds each byte in a one-deep buffer with ready/overrun/frame-error status until the CPU acknowledges the read.
- Sits between the board pin and the CPU1 peripheral bus decode.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVS, 16, oversampling ticks per bit; must be even and ≥8.
- DIV, CLK_FREQ/(BAUD*OVS) truncated (325 at defaults), clocks per oversample tick; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- rxd  in  1  raw serial input, idle high, asynchronous to clk.
- rx_ack  in  1  one-cycle pulse from the CPU read of the data register. Clears rx_ready, rx_overrun and rx_ferr.
- rx_data  out  8  last received byte, LSB first on the line.
- rx_valid  out  1  one-cycle pulse when a good byte is written to rx_data.
- rx_ready  out  1  sticky: an unread byte is in rx_data.
- rx_overrun  out  1  sticky: a byte was overwritten before it was acked.
- rx_ferr  out  1  sticky: stop bit sampled low.
- rx_busy  out  1  high while not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0, state IDLE, counters 0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame with no output.
- Input path:
  - 2-flop synchronizer on rxd; all logic uses the second flop (rxs).
  - Input latency is 2 clk.
- Tick generator:
  - Counter 0..DIV-1 with free run, tick pulse at DIV-1.
  - Restarted at 0 when leaving IDLE so phase aligns to the start edge.
- Sample counter: 0..OVS-1, advanced on tick. Bit counter: 0..7.
- FSM:
  - IDLE: rxs falling edge (prev 1, now 0) → START, clear counters.
  - START: at sample OVS/2-1 (mid-bit), if rxs=1 → IDLE (glitch rejected, no flags). Otherwise reset the sample counter → DATA.
  - DATA: at each sample OVS-1 (one bit period after the previous mid), shift rxs into shreg[7] with a right shift. After bit 7 → STOP.
  - STOP: at sample OVS-1, take the mid-stop sample.
    - rxs=1: rx_data←shreg, rx_valid=1 for exactly one clk, rx_ready←1 → IDLE.
    - rxs=0: rx_ferr←1, rx_data unchanged, no rx_valid → BREAK.
  - BREAK: wait until rxs=1 → IDLE. This prevents a held-low line from retriggering.
- Byte latency: rx_valid rises on the clk after the mid-stop tick, about 9.5 bit times after the start edge plus 2 clk of synchronizer delay.
- Status rules, evaluated in the same clk:
  - Good byte completes while rx_ready=1 and rx_ack=0: rx_overrun←1, data overwritten, rx_ready stays 1.
  - Good byte completes in the same clk as rx_ack: rx_ready=1, no overrun. New data wins and flags clear.
  - rx_ack alone: rx_ready, rx_overrun, rx_ferr←0; rx_data holds.
  - rx_ack when nothing is pending: no effect.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge half a bit later is caught. No dead time beyond that.
- Tolerance: sampling at mid-bit with DIV truncation. Default error is 0.16%, well within ±2% frame drift.

Test Plan:
- Reset then idle line: hold rxd=1 for 1 ms → all outputs 0, rx_busy=0 throughout.
- Single frame with 104167 ns bits, start then data 0,1,0,1,1,1,1,1 then stop → one rx_valid pulse, rx_data=0xFA, rx_ready=1, rx_ferr=0.
- Back-to-back frames 0xFA then 0x32 (data 0,1,0,0,1,1,0,0) with one idle bit between and no ack → rx_data=0x32, rx_overrun=1, rx_ready=1. Then pulse rx_ack → all three flags 0, rx_data stays 0x32.
- Glitch: rxd low for 3 µs then high → state returns to IDLE, no rx_valid, no flags. A following valid 0x55 frame is received correctly.
- Frame error: send 0xA5 with stop bit low, then hold rxd low 2 bit times, then high → rx_ferr=1, no rx_valid, rx_data unchanged, rx_busy stays high until rxd returns high. The next 0x3C frame is received.
- Corner cases:
  - Ack coincident with rx_valid → rx_ready=1, rx_overrun=0.
  - reset asserted at data bit 4 → outputs 0 immediately; the next full frame is received correctly.
